// File: rtl/fetch_queue_pkg.sv
// Shared fetch/decode definitions: word width, NOP and trap encodings, FIFO entry layout.
package fetch_queue_pkg;

    localparam int          WORD_W  = 16;
    localparam logic [15:0] NOP_ENC = 16'h0201;
    localparam logic [7:0]  TRAP_OP = 8'h00;

    typedef logic [WORD_W-1:0] word_t;

    typedef struct packed {
        word_t ir;
        word_t pc;
    } fetch_entry_t;

    typedef enum logic {
        RUN,
        STOPPED
    } fetch_state_e;

    function automatic logic [7:0] op_field(input word_t w);
        return w[15:8];
    endfunction

    function automatic logic is_trap(input word_t w);
        return op_field(w) == TRAP_OP;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of (ir, pc) fetch entries with push/pop/flush and an occupancy count.
module fetch_fifo
    import fetch_queue_pkg::*;
#(
    parameter int    DEPTH    = 4,
    parameter word_t NOP_WORD = NOP_ENC,
    localparam int   PTR_W    = $clog2(DEPTH),
    localparam int   CNT_W    = PTR_W + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               push,
    input  fetch_entry_t       push_entry,
    input  logic               pop,
    output logic [CNT_W-1:0]   count,
    output logic               head_valid,
    output word_t              head_ir,
    output word_t              head_pc
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; count alone decides which slots are valid.
    always_ff @(posedge clk) begin
        if (push && !flush && !reset) mem[wr_ptr] <= push_entry;
    end

    assign head_valid = (count != '0);
    assign head_ir    = head_valid ? mem[rd_ptr].ir : NOP_WORD;
    assign head_pc    = head_valid ? mem[rd_ptr].pc : '0;

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: issues imem reads, buffers (ir, pc) pairs, flushes on redirect, halts on trap.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int    DEPTH    = 4,
    parameter word_t NOP_WORD = NOP_ENC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        deq_ready,
    output logic        out_valid,
    output logic [15:0] out_ir,
    output logic [15:0] out_pc,
    output logic        stopped
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(DEPTH);

    fetch_state_e     state;
    word_t            fetch_pc;
    word_t            req_pc;
    logic             inflight;
    logic [CNT_W-1:0] count;
    logic [CNT_W:0]   pending;
    logic             accept;
    logic             pop;

    // Room check ignores a same-cycle dequeue, so a full queue can never overflow.
    assign pending   = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
    assign imem_req  = !reset && (state == RUN) && !redirect && (pending < DEPTH_L);
    assign imem_addr = fetch_pc;

    // Words arriving after a trap, during a redirect or after reset (inflight=0) are dropped.
    assign accept  = inflight && (state == RUN) && !redirect && !reset;
    assign pop     = out_valid && deq_ready && !redirect;
    assign stopped = (state == STOPPED);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            fetch_pc <= '0;
            req_pc   <= '0;
            inflight <= 1'b0;
        end else if (redirect) begin
            state    <= RUN;
            fetch_pc <= redirect_pc;
            inflight <= 1'b0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                fetch_pc <= fetch_pc + 16'd1;
                req_pc   <= fetch_pc;
            end
            if (accept && is_trap(imem_rdata)) state <= STOPPED;
        end
    end

    fetch_fifo #(
        .DEPTH    (DEPTH),
        .NOP_WORD (NOP_WORD)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect),
        .push       (accept),
        .push_entry ('{ir: imem_rdata, pc: req_pc}),
        .pop        (pop),
        .count      (count),
        .head_valid (out_valid),
        .head_ir    (out_ir),
        .head_pc    (out_pc)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: expected instruction stream per restart, monitor compares each dequeue.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata = 16'h0000;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        deq_ready = 1'b1;
    logic        out_valid;
    logic [15:0] out_ir;
    logic [15:0] out_pc;
    logic        stopped;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [15:0] ir;
        logic [15:0] pc;
    } exp_t;

    exp_t        sb_q[$];
    bit          trap_en = 1'b0;
    logic [15:0] trap_addr = 16'h0000;

    fetch_queue dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .deq_ready   (deq_ready),
        .out_valid   (out_valid),
        .out_ir      (out_ir),
        .out_pc      (out_pc),
        .stopped     (stopped)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (trap_en && a == trap_addr) return 16'h0000;
        return 16'h7010 + a;
    endfunction

    // Fetching restarted at 'start': decode must see start, start+1, ... up to and including the first trap.
    function void restart(input logic [15:0] start);
        logic [15:0] a;
        logic [15:0] w;
        sb_q.delete();
        a = start;
        for (int i = 0; i < 64; i++) begin
            w = mem_word(a);
            sb_q.push_back('{ir: w, pc: a});
            if (w[15:8] == 8'h00) break;
            a = a + 16'd1;
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock; imem answers the request seen in the cycle just ended, junk otherwise.
    task automatic tick();
        logic        req_d;
        logic [15:0] addr_d;
        #1;
        req_d  = imem_req;
        addr_d = imem_addr;
        @(posedge clk);
        #1;
        imem_rdata = req_d ? mem_word(addr_d) : 16'($urandom);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && !redirect) begin
                if (out_valid) begin
                    if (deq_ready) begin
                        if (sb_q.size() == 0) begin
                            vectors++;
                            miscompares++;
                            $display("FAIL unexpected_deq: got pc %0h ir %0h expected none", out_pc, out_ir);
                        end else begin
                            e = sb_q.pop_front();
                            check("deq_ir", {16'h0, out_ir}, {16'h0, e.ir});
                            check("deq_pc", {16'h0, out_pc}, {16'h0, e.pc});
                        end
                    end
                end else begin
                    check("empty_nop", {16'h0, out_ir}, {16'h0, NOP_ENC});
                end
            end
        end
    end

    initial begin : stimulus
        int r;
        // Reset state.
        run(2);
        #1;
        check("rst_req", {31'h0, imem_req}, 32'h0);
        check("rst_valid", {31'h0, out_valid}, 32'h0);
        check("rst_ir", {16'h0, out_ir}, {16'h0, NOP_ENC});
        check("rst_pc", {16'h0, out_pc}, 32'h0);
        check("rst_stopped", {31'h0, stopped}, 32'h0);

        // First request and first-word latency.
        reset = 1'b0;
        restart(16'h0000);
        #1;
        check("first_req", {31'h0, imem_req}, 32'h1);
        check("first_addr", {16'h0, imem_addr}, 32'h0);
        run(2);
        check("first_valid", {31'h0, out_valid}, 32'h1);
        run(5);

        // Back-pressure fills the queue and stops requests.
        deq_ready = 1'b0;
        run(8);
        #1;
        check("full_valid", {31'h0, out_valid}, 32'h1);
        check("full_noreq", {31'h0, imem_req}, 32'h0);
        deq_ready = 1'b1;
        run(10);

        // Redirect with entries queued and a response in flight.
        deq_ready = 1'b0;
        run(3);
        deq_ready = 1'b1;
        redirect = 1'b1;
        redirect_pc = 16'h0040;
        restart(16'h0040);
        #1;
        check("redir_noreq", {31'h0, imem_req}, 32'h0);
        tick();
        redirect = 1'b0;
        #1;
        check("redir_flush", {31'h0, out_valid}, 32'h0);
        check("redir_req", {31'h0, imem_req}, 32'h1);
        check("redir_addr", {16'h0, imem_addr}, 32'h40);
        run(2);
        check("redir_lat", {31'h0, out_valid}, 32'h1);
        check("redir_pc", {16'h0, out_pc}, 32'h40);
        run(4);

        // Trap at pc 5 halts fetching; queued words still drain.
        trap_en = 1'b1;
        trap_addr = 16'h0005;
        reset = 1'b1;
        restart(16'h0000);
        tick();
        reset = 1'b0;
        run(20);
        #1;
        check("trap_stopped", {31'h0, stopped}, 32'h1);
        check("trap_noreq", {31'h0, imem_req}, 32'h0);
        check("trap_empty", {31'h0, out_valid}, 32'h0);
        check("trap_drained", sb_q.size(), 32'h0);

        // Redirect out of the stopped state.
        trap_en = 1'b0;
        redirect = 1'b1;
        redirect_pc = 16'h0010;
        restart(16'h0010);
        tick();
        redirect = 1'b0;
        #1;
        check("restart_stopped", {31'h0, stopped}, 32'h0);
        check("restart_addr", {16'h0, imem_addr}, 32'h10);
        check("restart_req", {31'h0, imem_req}, 32'h1);
        run(6);

        // 16-bit PC wrap-around.
        redirect = 1'b1;
        redirect_pc = 16'hFFFE;
        restart(16'hFFFE);
        tick();
        redirect = 1'b0;
        run(8);

        // Reset while full.
        deq_ready = 1'b0;
        run(8);
        reset = 1'b1;
        deq_ready = 1'b1;
        restart(16'h0000);
        tick();
        reset = 1'b0;
        #1;
        check("midrst_valid", {31'h0, out_valid}, 32'h0);
        check("midrst_ir", {16'h0, out_ir}, {16'h0, NOP_ENC});
        check("midrst_req", {31'h0, imem_req}, 32'h1);
        check("midrst_addr", {16'h0, imem_addr}, 32'h0);
        run(6);

        // Randomized back-pressure, redirects and resets.
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            deq_ready = ($urandom_range(0, 9) < 7);
            if (r < 2) begin
                reset = 1'b1;
                restart(16'h0000);
            end else if (r < 8) begin
                redirect = 1'b1;
                redirect_pc = 16'($urandom);
                restart(redirect_pc);
            end
            tick();
            reset = 1'b0;
            redirect = 1'b0;
        end
        run(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
